// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - dot-product sequencer feeding one 16-lane MAC and accumulating its chunk sums.
// Optional build macro MAC_SEQ_CTRL_RELU_EN clamps negative results to zero.
module mac_seq_ctrl #(
    parameter int N       = 16,
    parameter int WI      = 8,
    parameter int MAC_LAT = 5,
    parameter int WS      = 2*WI + $clog2(N) + 2,
    parameter int WK      = 8,
    parameter int WA      = 10,
    parameter int WACC    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WK-1:0]     cfg_num_chunks,
    input  logic [WA-1:0]     cfg_wbase,
    input  logic [WA-1:0]     cfg_abase,
    output logic              busy,
    output logic              buf_re,
    output logic [WA-1:0]     wbuf_addr,
    output logic [WA-1:0]     abuf_addr,
    input  logic [N*WI-1:0]   wbuf_data,
    input  logic [N*WI-1:0]   abuf_data,
    output logic              mac_vld_i,
    output logic [N*WI-1:0]   mac_win,
    output logic [N*WI-1:0]   mac_din,
    input  logic [WS-1:0]     mac_acc_o,
    input  logic              mac_vld_o,
    output logic [WACC-1:0]   out_data,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [WK-1:0]   num_q, num_d;
    logic [WA-1:0]   wbase_q, wbase_d;
    logic [WA-1:0]   abase_q, abase_d;
    logic [WK-1:0]   issue_cnt_q, issue_cnt_d;
    logic [WK-1:0]   recv_cnt_q, recv_cnt_d;
    logic [WACC-1:0] acc_q, acc_d;
    logic [WACC-1:0] out_data_q, out_data_d;
    logic            mac_vld_q, mac_vld_d;

    logic            sum_accept;
    logic [WACC-1:0] sum_ext;

    function automatic logic [WACC-1:0] result_op(input logic [WACC-1:0] a);
`ifdef MAC_SEQ_CTRL_RELU_EN
        return a[WACC-1] ? '0 : a;
`else
        return a;
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            num_q       <= '0;
            wbase_q     <= '0;
            abase_q     <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            mac_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            wbase_q     <= wbase_d;
            abase_q     <= abase_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            mac_vld_q   <= mac_vld_d;
        end
    end

    // Sums are only meaningful while a run is in flight; stray pulses elsewhere are dropped.
    assign sum_accept = mac_vld_o && ((state_q == S_ISSUE) || (state_q == S_DRAIN));
    assign sum_ext    = {{(WACC-WS){mac_acc_o[WS-1]}}, mac_acc_o};

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        wbase_d     = wbase_q;
        abase_d     = abase_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        mac_vld_d   = (state_q == S_ISSUE);

        if (sum_accept) begin
            acc_d      = acc_q + sum_ext;
            recv_cnt_d = recv_cnt_q + WK'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d       = cfg_num_chunks;
                    wbase_d     = cfg_wbase;
                    abase_d     = cfg_abase;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    acc_d       = '0;
                    if (cfg_num_chunks == '0) begin
                        out_data_d = '0;
                        state_d    = S_OUT;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                issue_cnt_d = issue_cnt_q + WK'(1);
                if (issue_cnt_q == num_q - WK'(1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Compare against the post-accumulate count so the final sum lands in the result.
                if (recv_cnt_d == num_q) begin
                    out_data_d = result_op(acc_d);
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (out_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign buf_re    = (state_q == S_ISSUE);
    assign wbuf_addr = buf_re ? (wbase_q + WA'(issue_cnt_q)) : '0;
    assign abuf_addr = buf_re ? (abase_q + WA'(issue_cnt_q)) : '0;

    assign mac_vld_i = mac_vld_q;
    assign mac_win   = mac_vld_q ? wbuf_data : '0;
    assign mac_din   = mac_vld_q ? abuf_data : '0;

    assign out_vld   = (state_q == S_OUT);
    assign out_data  = out_data_q;
    assign done      = (state_q == S_OUT) && out_rdy;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - directed bench for mac_seq_ctrl with a sign-weight MAC and buffer models.
module tb_mac_seq_ctrl;

    localparam int N = 16, WI = 8, MAC_LAT = 5, WS = 22, WK = 8, WA = 10, WACC = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [WK-1:0]     cfg_num_chunks;
    logic [WA-1:0]     cfg_wbase;
    logic [WA-1:0]     cfg_abase;
    logic              busy;
    logic              buf_re;
    logic [WA-1:0]     wbuf_addr;
    logic [WA-1:0]     abuf_addr;
    logic [N*WI-1:0]   wbuf_data;
    logic [N*WI-1:0]   abuf_data;
    logic              mac_vld_i;
    logic [N*WI-1:0]   mac_win;
    logic [N*WI-1:0]   mac_din;
    logic [WS-1:0]     mac_acc_o;
    logic              mac_vld_o;
    logic [WACC-1:0]   out_data;
    logic              out_vld;
    logic              out_rdy;
    logic              done;

    int checks = 0;
    int failures = 0;

    mac_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .cfg_num_chunks(cfg_num_chunks),
        .cfg_wbase(cfg_wbase), .cfg_abase(cfg_abase), .busy(busy), .buf_re(buf_re),
        .wbuf_addr(wbuf_addr), .abuf_addr(abuf_addr), .wbuf_data(wbuf_data),
        .abuf_data(abuf_data), .mac_vld_i(mac_vld_i), .mac_win(mac_win), .mac_din(mac_din),
        .mac_acc_o(mac_acc_o), .mac_vld_o(mac_vld_o), .out_data(out_data), .out_vld(out_vld),
        .out_rdy(out_rdy), .done(done)
    );

    always #5 clk = ~clk;

    // Buffers: one-cycle read latency.
    logic [N*WI-1:0] wmem [1024];
    logic [N*WI-1:0] amem [1024];
    always @(posedge clk) begin
        wbuf_data <= wmem[wbuf_addr];
        abuf_data <= amem[abuf_addr];
    end

    // MAC stand-in: weight MSB selects -1 else +1, activations unsigned; not reset, so in-flight sums leak out.
    function automatic logic [WS-1:0] mac_model(input logic [N*WI-1:0] w, input logic [N*WI-1:0] d);
        int s;
        s = 0;
        for (int i = 0; i < N; i++) begin
            int v;
            v = int'(d[i*WI +: WI]);
            s += w[i*WI + WI - 1] ? -v : v;
        end
        return s[WS-1:0];
    endfunction

    logic [MAC_LAT-1:0] vpipe;
    logic [WS-1:0]      spipe [MAC_LAT];
    always @(posedge clk) begin
        vpipe    <= {vpipe[MAC_LAT-2:0], mac_vld_i};
        spipe[0] <= mac_model(mac_win, mac_din);
        for (int i = 1; i < MAC_LAT; i++) spipe[i] <= spipe[i-1];
    end
    assign mac_vld_o = vpipe[MAC_LAT-1];
    assign mac_acc_o = spipe[MAC_LAT-1];

    int re_cnt = 0, mvi_cnt = 0, done_cnt = 0;
    logic [WA-1:0] addr_log [$];
    always @(negedge clk) begin
        if (buf_re) begin
            re_cnt++;
            addr_log.push_back(wbuf_addr);
        end
        if (mac_vld_i) mvi_cnt++;
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [WA-1:0] wa, input logic [WA-1:0] aa,
                        input logic [7:0] wv, input logic [7:0] dv);
        wmem[wa] = {N{wv}};
        amem[aa] = {N{dv}};
    endtask

    task automatic run_to_vld(input int k, input logic [WA-1:0] wb, input logic [WA-1:0] ab,
                              output int lat);
        @(posedge clk); #1;
        cfg_num_chunks = WK'(k);
        cfg_wbase = wb;
        cfg_abase = ab;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!out_vld && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_vld) chk("vld_timeout", 64'd0, 64'd1);
    endtask

    task automatic handshake(input string tag, input logic [WACC-1:0] exp);
        int d0;
        d0 = done_cnt;
        chk({tag, "_data"}, 64'(out_data), 64'(exp));
        chk({tag, "_done_pre"}, 64'(done), 64'd0);
        out_rdy = 1'b1;
        #1;
        chk({tag, "_done_hs"}, 64'(done), 64'd1);
        @(posedge clk); #1;
        out_rdy = 1'b0;
        chk({tag, "_vld_after"}, 64'(out_vld), 64'd0);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
        chk({tag, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int lat, r0, m0, q0, busy_hits;
        logic [WACC-1:0] exp_neg;
        vpipe = '0;
        for (int i = 0; i < MAC_LAT; i++) spipe[i] = '0;
        for (int i = 0; i < 1024; i++) begin
            wmem[i] = '0;
            amem[i] = '0;
        end
        rst = 1'b1; start = 1'b0; out_rdy = 1'b0;
        cfg_num_chunks = '0; cfg_wbase = '0; cfg_abase = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_buf_re", 64'(buf_re), 64'd0);
        chk("rst_mac_vld_i", 64'(mac_vld_i), 64'd0);
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_addr", 64'({wbuf_addr, abuf_addr}), 64'd0);
        chk("rst_mac_win", 64'(mac_win[63:0]), 64'd0);

        // 1: K=4, +1 weights, din=1 -> 4*16 = 64, out_vld at c11
        for (int j = 0; j < 4; j++) fill(WA'(j), WA'(10'h200 + j), 8'h00, 8'h01);
        r0 = re_cnt; m0 = mvi_cnt;
        run_to_vld(4, 10'h000, 10'h200, lat);
        chk("t1_lat", 64'(lat), 64'd11);
        chk("t1_re_cnt", 64'(re_cnt - r0), 64'd4);
        chk("t1_mvi_cnt", 64'(mvi_cnt - m0), 64'd4);
        handshake("t1", 32'd64);

        // 2: K=1, -1 weights, din=255 -> -4080
        fill(10'h010, 10'h210, 8'hFF, 8'hFF);
        run_to_vld(1, 10'h010, 10'h210, lat);
        chk("t2_lat", 64'(lat), 64'd8);
`ifdef MAC_SEQ_CTRL_RELU_EN
        exp_neg = 32'h0000_0000;
`else
        exp_neg = 32'hFFFF_F010;
`endif
        handshake("t2", exp_neg);

        // 3: K=0 -> result 0 the next cycle, no reads
        r0 = re_cnt;
        run_to_vld(0, 10'h000, 10'h000, lat);
        chk("t3_lat", 64'(lat), 64'd1);
        chk("t3_re_cnt", 64'(re_cnt - r0), 64'd0);
        handshake("t3", 32'd0);

        // 4: K=8, chunk j din=j+1 -> 16*36 = 576, stalled 10 cycles with an ignored start
        for (int j = 0; j < 8; j++) fill(WA'(10'h020 + j), WA'(10'h220 + j), 8'h00, 8'(j + 1));
        run_to_vld(8, 10'h020, 10'h220, lat);
        chk("t4_lat", 64'(lat), 64'd15);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                start = 1'b1;
                cfg_num_chunks = 8'd5;
            end
            if (i == 4) start = 1'b0;
            chk("t4_stall_data", 64'(out_data), 64'd576);
            chk("t4_stall_done", 64'(done), 64'd0);
            chk("t4_stall_busy", 64'(busy), 64'd1);
            @(posedge clk); #1;
        end
        handshake("t4", 32'd576);
        @(posedge clk); #1;
        chk("t4_start_ignored", 64'(busy), 64'd0);

        // 5: K=16 from wbase 0x3F8 wraps; din=2 -> 16*16*2 = 512
        for (int j = 0; j < 16; j++) fill(WA'(10'h3F8 + j), WA'(10'h100 + j), 8'h00, 8'h02);
        r0 = re_cnt; m0 = mvi_cnt; q0 = addr_log.size();
        run_to_vld(16, 10'h3F8, 10'h100, lat);
        chk("t5_re_cnt", 64'(re_cnt - r0), 64'd16);
        chk("t5_mvi_cnt", 64'(mvi_cnt - m0), 64'd16);
        for (int j = 0; j < 16; j++) begin
            logic [WA-1:0] ea;
            ea = WA'(10'h3F8 + j);
            chk("t5_wbuf_addr", 64'(addr_log[q0 + j]), 64'(ea));
        end
        handshake("t5", 32'd512);

        // 6: reset at c3 of a K=8 run, stale sums ignored, then a clean K=2 run
        for (int j = 0; j < 8; j++) fill(WA'(10'h040 + j), WA'(10'h240 + j), 8'h00, 8'h07);
        @(posedge clk); #1;
        cfg_num_chunks = 8'd8; cfg_wbase = 10'h040; cfg_abase = 10'h240; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_buf_re", 64'(buf_re), 64'd0);
        chk("t6_mac_vld_i", 64'(mac_vld_i), 64'd0);
        chk("t6_out", 64'({out_vld, done}), 64'd0);
        chk("t6_out_data", 64'(out_data), 64'd0);
        chk("t6_addr", 64'({wbuf_addr, abuf_addr}), 64'd0);
        busy_hits = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy || out_vld) busy_hits++;
            @(posedge clk); #1;
        end
        chk("t6_idle_hold", 64'(busy_hits), 64'd0);
        fill(10'h060, 10'h260, 8'h00, 8'h05);
        fill(10'h061, 10'h261, 8'hFF, 8'h02);
        run_to_vld(2, 10'h060, 10'h260, lat);
        chk("t6_lat", 64'(lat), 64'd9);
        handshake("t6", 32'd48);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequences one dot product of length cfg_num_chunks*N through the 16-lane pipelined MAC.
- Streams N-wide weight and activation chunks from the weight and activation buffers into the MAC.
- Accumulates the per-chunk MAC sums into a wide signed accumulator and presents the final result on a valid/ready output.
- Sits between the layer scheduler (start/done) and one MAC instance.

Parameters:
N, 16, MAC lanes per chunk
WI, 8, bits per weight/activation element
MAC_LAT, 5, cycles from mac_vld_i to mac_vld_o ($clog2(N)+1)
WS, 2*WI+$clog2(N)+2, MAC sum width (22 at defaults)
WK, 8, chunk-count width
WA, 10, buffer address width
WACC, 32, accumulator/result width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  single-cycle request to run, sampled in IDLE only
cfg_num_chunks  in  WK  chunks to process, sampled on accepted start
cfg_wbase  in  WA  weight buffer base address, sampled on start
cfg_abase  in  WA  activation buffer base address, sampled on start
busy  out  1  high whenever not IDLE
buf_re  out  1  buffer read strobe; data returns the next cycle
wbuf_addr  out  WA  weight buffer address
abuf_addr  out  WA  activation buffer address
wbuf_data  in  N*WI  weight chunk (1-cycle read latency)
abuf_data  in  N*WI  activation chunk (1-cycle read latency)
mac_vld_i  out  1  chunk valid to MAC
mac_win  out  N*WI  weights to MAC
mac_din  out  N*WI  activations to MAC
mac_acc_o  in  WS  signed MAC chunk sum
mac_vld_o  in  1  MAC sum valid
out_data  out  WACC  signed result
out_vld  out  1  result valid
out_rdy  in  1  downstream ready
done  out  1  one-cycle pulse on result handshake

Behaviour:
- Reset: FSM=IDLE; all counters and accumulator 0. busy, buf_re, mac_vld_i, out_vld and done are 0. Addresses, out_data and mac_win/mac_din are 0.
- Reset mid-operation aborts the run. MAC sums arriving while in IDLE are ignored. The MAC's own reset is driven with ~rst at integration.
- IDLE:
  - start=1 with cfg_num_chunks>0: latch config, clear the accumulator and issue/receive counters, go to ISSUE.
  - start=1 with cfg_num_chunks=0: go directly to OUT with result 0.
- ISSUE:
  - buf_re=1 every cycle; addresses are base+issue_cnt.
  - After cfg_num_chunks reads, go to DRAIN.
  - No back-pressure in ISSUE (one chunk per cycle).
- MAC feed: mac_vld_i is buf_re delayed 1 cycle. mac_win/mac_din are driven combinationally from wbuf_data/abuf_data while mac_vld_i=1, and are 0 otherwise.
- Accumulate: on each mac_vld_o, acc <= acc + sign-extend(mac_acc_o) and recv_cnt++. The accumulator wraps modulo 2^WACC.
- mac_vld_o is accepted in ISSUE or DRAIN. A pulse arriving in OUT or IDLE is an error and is ignored.
- DRAIN: when recv_cnt==cfg_num_chunks, go to OUT. A last accumulate and the transition in the same cycle use the updated sum.
- OUT:
  - out_vld=1 and out_data=acc, held stable until out_rdy=1.
  - On the handshake: done=1 for one cycle, out_vld drops, go to IDLE.
- Latency:
  - Start-accept cycle = c0; last read at c(K); last mac_vld_i at c(K+1); last mac_vld_o at c(K+1+MAC_LAT).
  - out_vld rises at c(K+MAC_LAT+2).
- Back-to-back: start in the same cycle as done is ignored (FSM is still leaving OUT). The next start is accepted from IDLE the following cycle.
- cfg_* changes while busy have no effect.

Optional Feature:
- MAC_SEQ_CTRL_RELU_EN defined: out_data = (acc<0) ? 0 : acc, computed at OUT entry.
- Undefined: out_data = acc unmodified.
- Accumulation itself is always signed and unchanged.

Test Plan:
1. Use the real MAC, K=4, every chunk win=0 (weight encodes +1), din=1 → each sum 16. out_data=64; out_vld at c11; done pulses on the handshake cycle.
2. K=1, win=0xFF (weight -1), din=0xFF → sum -4080. out_data=-4080 (0xFFFFF010) without RELU_EN; 0 with RELU_EN.
3. K=0 start → out_vld the next cycle with out_data=0; buf_re never asserted.
4. K=8 with out_rdy held low 10 cycles after out_vld → out_data stable, no done until out_rdy=1. A start during the stall is ignored; busy stays 1.
5. K=16, wbase=0x3F8 → wbuf_addr runs 0x3F8..0x007 (wraps at 2^WA); 16 buf_re pulses, 16 mac_vld_i pulses.
6. rst asserted at c3 of a K=8 run → next cycle all outputs 0, FSM IDLE. Late mac_vld_o pulses are ignored. A new K=2 run then yields the correct sum.
